// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit : program counter and next-PC selection for a single-cycle MIPS core.
//
// Holds the architectural PC and picks the next fetch address from sequential,
// branch (beq/bne using the ALU Zero flag), jump (j/jal) and register-jump (jr)
// targets. Provides a stall hold and a terminal HALT state that only reset
// leaves.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a jr whose target is not word-aligned does not update the PC;
//               it halts the unit and sets the sticky excAddr flag.
//   undefined : the jr target is forced word-aligned; excAddr is tied to 0.
//
// Ports
//   clk         in   clock, rising-edge active
//   reset_n     in   asynchronous active-low reset
//   stall       in   hold PC this cycle
//   halt        in   request entry to HALT
//   nPCop[2:0]  in   next-PC select (000 seq, 001 beq, 010 bne, 011 j, 100 jr)
//   Zero        in   ALU zero flag of the current instruction
//   imm16[15:0] in   signed branch offset in words
//   instrIndex  in   26-bit jump index
//   rsData      in   register value for jr
//   PC          out  current PC (registered)
//   PCplus4     out  PC + 4 (combinational, jal link value)
//   redirect    out  1 when the selected next PC is not PC + 4
//   halted      out  1 while in HALT (registered)
//   excAddr     out  sticky misaligned-jr flag
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        halt,
    input  logic [2:0]  nPCop,
    input  logic        Zero,
    input  logic [15:0] imm16,
    input  logic [25:0] instrIndex,
    input  logic [31:0] rsData,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        redirect,
    output logic        halted,
    output logic        excAddr
);

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_BNE = 3'b010;
    localparam logic [2:0] NPC_J   = 3'b011;
    localparam logic [2:0] NPC_JR  = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic        [31:0] pc_q, pc_d;
    logic        [31:0] pc_plus4;
    logic signed [31:0] br_off;
    logic        [31:0] br_target;
    logic        [31:0] j_target;
    logic        [31:0] jr_target;
    logic        [31:0] npc;
    logic               misaligned_jr;

    assign pc_plus4  = pc_q + 32'd4;
    // Word offset sign-extended and scaled to bytes in one concatenation.
    assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target = pc_plus4 + $unsigned(br_off);
    assign j_target  = {pc_plus4[31:28], instrIndex, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    assign jr_target     = rsData;
    assign misaligned_jr = (nPCop == NPC_JR) && (rsData[1:0] != 2'b00);
`else
    // Low address bits are dropped so fetch always stays word-aligned.
    assign jr_target     = rsData & ~32'h0000_0003;
    assign misaligned_jr = 1'b0;
`endif

    // Next-PC mux; reserved encodings fall through to sequential.
    always_comb begin
        npc = pc_plus4;
        case (nPCop)
            NPC_SEQ: npc = pc_plus4;
            NPC_BEQ: if (Zero)  npc = br_target;
            NPC_BNE: if (!Zero) npc = br_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = jr_target;
            default: npc = pc_plus4;
        endcase
    end

    // A target equal to PC+4 (e.g. not-taken branch, zero offset) is not a
    // redirect. A trapped jr never redirects since the PC will not move.
    assign redirect = (state_q == ST_RUN) && !stall && !misaligned_jr &&
                      (npc != pc_plus4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (misaligned_jr) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = npc;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic exc_q, exc_d;

    // Sticky: once a trapped jr is seen, the flag stays until reset.
    assign exc_d = exc_q |
                   ((state_q == ST_RUN) && !halt && !stall && misaligned_jr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign excAddr = exc_q;
`else
    assign excAddr = 1'b0;
`endif

    assign PC      = pc_q;
    assign PCplus4 = pc_plus4;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and next-PC stage of the single-cycle MIPS datapath. Holds the architectural PC and supplies the current fetch address and link value (PC+4). Each cycle it selects the next PC from sequential, branch, jump or register-jump targets, using the ALU `Zero` flag for conditional branches. It also provides a stall hold and a terminal HALT state.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold the PC this cycle.
- `halt`  in  1  request entry to HALT.
- `nPCop`  in  3  next-PC select:
  - 000 sequential
  - 001 beq, taken if `Zero`
  - 010 bne, taken if !`Zero`
  - 011 j/jal
  - 100 jr
  - 101–111 treated as 000
- `Zero`  in  1  ALU zero flag for the current instruction.
- `imm16`  in  16  branch offset in words, signed.
- `instrIndex`  in  26  jump index field.
- `rsData`  in  32  register value for jr.
- `PC`  out  32  current PC (registered).
- `PCplus4`  out  32  PC+4, combinational; link value for jal.
- `redirect`  out  1  combinational; 1 when the selected next PC is not PC+4.
- `halted`  out  1  registered; 1 in HALT.
- `excAddr`  out  1  sticky misaligned-jr flag (see Configuration).

## Operation
- Arithmetic is 32-bit unsigned with wrap-around; no overflow detection.
- PCplus4 = PC + 4. At PC = 0xFFFF_FFFC, PCplus4 = 0x0000_0000.
- Branch target = PCplus4 + (sign_extend(imm16) << 2).
- Jump target = {PCplus4[31:28], instrIndex, 2'b00}.
- jr target = rsData.
- NPC is chosen by `nPCop`. A not-taken beq/bne selects PCplus4.
- FSM has two states, RUN and HALT.
  - Reset enters RUN.
  - RUN → HALT when `halt` = 1 at a clock edge.
  - HALT → HALT until `reset_n` is asserted.
- RUN, per clock edge, in priority order:
  1. `halt`: PC holds and the state goes to HALT.
  2. `stall`: PC holds.
  3. Otherwise PC ← NPC.
- In HALT, PC holds and all inputs except `reset_n` are ignored.
- `redirect` is forced to 0 whenever the state is HALT or `stall` = 1.
- Reset values: PC = RESET_PC, halted = 0, excAddr = 0.
- Reset asserted mid-operation takes effect immediately, independent of `clk`. It overrides stall, halt and HALT.

## Timing
- PC update latency is one cycle. The NPC computed in cycle n appears on `PC` after edge n.
- `PCplus4` and `redirect` settle combinationally from `PC` and the inputs within the same cycle.
- `halted` rises on the edge that samples `halt` = 1. The PC from before that edge remains on `PC`.
- Simultaneous `halt` and `stall`: halt wins.
- Simultaneous `halt` and a taken branch: the branch is discarded and the PC holds.
- On `reset_n` deassertion, the first PC update occurs on the next rising edge.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined: a jr with rsData[1:0] ≠ 00 does not update PC. The edge where the check applies is RUN, `stall` = 0, `halt` = 0. On that edge:
  - the FSM enters HALT;
  - `excAddr` is set and stays 1 until reset;
  - `redirect` reads 0 for that instruction.
- Undefined: the jr target is {rsData[31:2], 2'b00}. `excAddr` is tied to 0.

## Test plan
- Reset, then release with `nPCop` = 000 and no stall → PC = 0x3000, 0x3004, 0x3008 on successive edges; `halted` = 0.
- PC = 0x3008, `nPCop` = 001, `Zero` = 1, `imm16` = 0xFFFE → `redirect` = 1, next PC = 0x3004. Repeat with `Zero` = 0 → next PC = 0x300C, `redirect` = 0.
- PC = 0x3010, `nPCop` = 011, `instrIndex` = 0x0000C10 → `PCplus4` = 0x3014, next PC = 0x0000_3040.
- `nPCop` = 100, `rsData` = 0x0000_3002:
  - with `PC_ALIGN_CHECK_EN`: PC holds, `halted` = 1, `excAddr` = 1;
  - without it: next PC = 0x3000.
- `stall` = 1 for 3 cycles at PC = 0x3020 with `nPCop` = 011 → PC stays 0x3020 and `redirect` = 0 throughout. Assert `halt` together with `stall` → `halted` = 1 and PC = 0x3020 held for 10 further cycles.
- Assert `reset_n` = 0 mid-cycle while in HALT → PC = 0x3000, `halted` = 0 and `excAddr` = 0 immediately, without waiting for a clock edge.
